vexec_lane_sequencer: RTL and testbench

- Multi-cycle sequencer that executes vector ALU ops (VADD/VADDI/VAND/VANDI/VMOV/VMOVI) by stepping a narrow lane ALU across the vector register.
- Sits between decode and memory, beside the scalar execute stage, so the full-width vector datapath is shared over time.
- Accepts one op via valid/ready and holds the result until memory accepts it.

---
 rtl/vexec_pkg.sv | 22 ++
 rtl/vexec_lane_alu.sv | 29 ++
 rtl/vexec_lane_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_vexec_lane_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vexec_pkg.sv
// Shared definitions for the vector lane sequencer: op encodings, FSM states, default geometry.
package vexec_pkg;

    localparam int NUM_LANES_DEF = 4;
    localparam int LANE_W_DEF    = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_AND  = 3'd2,
        OP_ANDI = 3'd3,
        OP_MOV  = 3'd4,
        OP_MOVI = 3'd5
    } opsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vexec_lane_alu.sv
// Combinational single-lane ALU; unknown op selects produce zero and raise o_illegal.
module vexec_lane_alu
    import vexec_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic [2:0]        i_opsel,
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    input  logic [LANE_W-1:0] i_imm,
    output logic [LANE_W-1:0] o_y,
    output logic              o_illegal
);

    always_comb begin
        o_y       = '0;
        o_illegal = 1'b0;
        case (i_opsel)
            OP_ADD:  o_y = i_a + i_b;
            OP_ADDI: o_y = i_a + i_imm;
            OP_AND:  o_y = i_a & i_b;
            OP_ANDI: o_y = i_a & i_imm;
            OP_MOV:  o_y = i_b;
            OP_MOVI: o_y = i_imm;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/vexec_lane_sequencer.sv
// Time-multiplexed vector ALU: steps LANES_PER_STEP lanes per negedge across the vector register.
// Optional lane masking with step skipping when VEXEC_LANE_MASK_EN is defined.
module vexec_lane_sequencer
    import vexec_pkg::*;
#(
    parameter  int NUM_LANES      = NUM_LANES_DEF,
    parameter  int LANE_W         = LANE_W_DEF,
    parameter  int LANES_PER_STEP = 1,
    localparam int VREG_W         = NUM_LANES * LANE_W
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET_N,
    input  logic              I_Valid,
    output logic              O_Ready,
    input  logic [2:0]        I_OpSel,
    input  logic [3:0]        I_DestRegIdx,
    input  logic [VREG_W-1:0] I_VSrc1Value,
    input  logic [VREG_W-1:0] I_VSrc2Value,
    input  logic [LANE_W-1:0] I_Imm,
`ifdef VEXEC_LANE_MASK_EN
    input  logic [NUM_LANES-1:0] I_LaneMask,
    input  logic [VREG_W-1:0]    I_VDestValue,
`endif
    input  logic              I_Flush,
    output logic              O_Valid,
    input  logic              I_Ready,
    output logic [VREG_W-1:0] O_VALUOut,
    output logic [3:0]        O_DestRegIdx,
    output logic              O_IllegalOp,
    output logic              O_Busy,
    output logic [1:0]        O_DbgState
);

    localparam int S      = NUM_LANES / LANES_PER_STEP;
    localparam int STEP_W = $clog2(S + 1);

    if (NUM_LANES % LANES_PER_STEP != 0) begin : g_bad_geometry
        $error("NUM_LANES must be a multiple of LANES_PER_STEP");
    end

    state_e              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [VREG_W-1:0]   r_src1;
    logic [VREG_W-1:0]   r_src2;
    logic [LANE_W-1:0]   r_imm;
    logic [2:0]          r_opsel;
    logic [3:0]          r_dest;
    logic [VREG_W-1:0]   r_out;
    logic                r_valid;
    logic                r_illegal;

    int                  w_base;
    logic [STEP_W-1:0]   w_next;
    logic [STEP_W-1:0]   w_first;
    logic [VREG_W-1:0]   w_accept_out;
    logic [LANES_PER_STEP-1:0] w_lane_en;
    logic [LANE_W-1:0]   w_lane_y [LANES_PER_STEP];
    logic [LANES_PER_STEP-1:0] w_lane_ill;

`ifdef VEXEC_LANE_MASK_EN
    logic [NUM_LANES-1:0] r_mask;

    // Lowest step at or after 'from' that has any enabled lane; S when none remain.
    function automatic logic [STEP_W-1:0] next_step(input logic [NUM_LANES-1:0] m, input int from);
        logic [STEP_W-1:0] n;
        n = STEP_W'(S);
        for (int s = S - 1; s >= 0; s--) begin
            if (s >= from && |m[s*LANES_PER_STEP +: LANES_PER_STEP]) n = STEP_W'(s);
        end
        return n;
    endfunction

    always_comb begin
        w_first      = next_step(I_LaneMask, 0);
        w_next       = next_step(r_mask, int'(r_step) + 1);
        w_accept_out = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (!I_LaneMask[l]) w_accept_out[l*LANE_W +: LANE_W] = I_VDestValue[l*LANE_W +: LANE_W];
        end
        w_lane_en = r_mask[w_base +: LANES_PER_STEP];
    end
`else
    always_comb begin
        w_first      = '0;
        w_next       = r_step + 1'b1;
        w_accept_out = '0;
        w_lane_en    = '1;
    end
`endif

    // Clamp so the ALU operand slices stay in range when no step is pending.
    always_comb begin
        w_base = 0;
        if (int'(r_step) < S) w_base = int'(r_step) * LANES_PER_STEP;
    end

    for (genvar j = 0; j < LANES_PER_STEP; j++) begin : g_lane
        vexec_lane_alu #(.LANE_W(LANE_W)) u_alu (
            .i_opsel   (r_opsel),
            .i_a       (r_src1[(w_base + j)*LANE_W +: LANE_W]),
            .i_b       (r_src2[(w_base + j)*LANE_W +: LANE_W]),
            .i_imm     (r_imm),
            .o_y       (w_lane_y[j]),
            .o_illegal (w_lane_ill[j])
        );
    end

    // Handshakes: an upstream op transfers on an edge where I_Valid && O_Ready (O_Ready only in IDLE);
    // a result transfers on an edge where O_Valid && I_Ready, and is held unchanged until then.
    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state   <= ST_IDLE;
            r_step    <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_imm     <= '0;
            r_opsel   <= '0;
            r_dest    <= '0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
`ifdef VEXEC_LANE_MASK_EN
            r_mask    <= '0;
`endif
        end else if (I_Flush) begin
            if (r_state != ST_IDLE) begin
                r_state   <= ST_IDLE;
                r_valid   <= 1'b0;
                r_illegal <= 1'b0;
                r_out     <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (I_Valid) begin
                        r_src1    <= I_VSrc1Value;
                        r_src2    <= I_VSrc2Value;
                        r_imm     <= I_Imm;
                        r_opsel   <= I_OpSel;
                        r_dest    <= I_DestRegIdx;
                        r_out     <= w_accept_out;
                        r_illegal <= 1'b0;
                        r_step    <= w_first;
`ifdef VEXEC_LANE_MASK_EN
                        r_mask    <= I_LaneMask;
`endif
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (int'(r_step) >= S) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_illegal <= |w_lane_ill;
                    end else begin
                        for (int j = 0; j < LANES_PER_STEP; j++) begin
                            if (w_lane_en[j]) r_out[(w_base + j)*LANE_W +: LANE_W] <= w_lane_y[j];
                        end
                        r_step <= w_next;
                        if (int'(w_next) >= S) begin
                            r_state   <= ST_DONE;
                            r_valid   <= 1'b1;
                            r_illegal <= |w_lane_ill;
                        end
                    end
                end
                ST_DONE: begin
                    if (I_Ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign O_Ready      = (r_state == ST_IDLE);
    assign O_Busy       = (r_state != ST_IDLE);
    assign O_Valid      = r_valid;
    assign O_VALUOut    = r_out;
    assign O_DestRegIdx = r_dest;
    assign O_IllegalOp  = r_illegal;
    assign O_DbgState   = r_state;

endmodule

// File: tb/tb_vexec_lane_sequencer.sv
// Directed bench for vexec_lane_sequencer: latency, arithmetic, backpressure, flush, reset, illegal ops.
module tb_vexec_lane_sequencer;

  logic        I_CLOCK;
  logic        I_RESET_N;
  logic        I_Valid;
  logic        O_Ready;
  logic [2:0]  I_OpSel;
  logic [3:0]  I_DestRegIdx;
  logic [63:0] I_VSrc1Value;
  logic [63:0] I_VSrc2Value;
  logic [15:0] I_Imm;
  logic        I_Flush;
  logic        O_Valid;
  logic        I_Ready;
  logic [63:0] O_VALUOut;
  logic [3:0]  O_DestRegIdx;
  logic        O_IllegalOp;
  logic        O_Busy;
  logic [1:0]  O_DbgState;
`ifdef VEXEC_LANE_MASK_EN
  logic [3:0]  I_LaneMask;
  logic [63:0] I_VDestValue;
`endif

  int n_vec = 0;
  int n_err = 0;

  vexec_lane_sequencer dut (
    .I_CLOCK      (I_CLOCK),
    .I_RESET_N    (I_RESET_N),
    .I_Valid      (I_Valid),
    .O_Ready      (O_Ready),
    .I_OpSel      (I_OpSel),
    .I_DestRegIdx (I_DestRegIdx),
    .I_VSrc1Value (I_VSrc1Value),
    .I_VSrc2Value (I_VSrc2Value),
    .I_Imm        (I_Imm),
`ifdef VEXEC_LANE_MASK_EN
    .I_LaneMask   (I_LaneMask),
    .I_VDestValue (I_VDestValue),
`endif
    .I_Flush      (I_Flush),
    .O_Valid      (O_Valid),
    .I_Ready      (I_Ready),
    .O_VALUOut    (O_VALUOut),
    .O_DestRegIdx (O_DestRegIdx),
    .O_IllegalOp  (O_IllegalOp),
    .O_Busy       (O_Busy),
    .O_DbgState   (O_DbgState)
  );

  // Clock / reset: DUT updates on negedge, bench drives and samples on posedge.
  initial I_CLOCK = 1'b1;
  always #5 I_CLOCK = ~I_CLOCK;

  task automatic tick;
    @(negedge I_CLOCK);
    @(posedge I_CLOCK);
  endtask

  task automatic start_op(input logic [2:0] op, input logic [3:0] dest,
                          input logic [63:0] s1, input logic [63:0] s2, input logic [15:0] imm);
    I_Valid = 1'b1; I_OpSel = op; I_DestRegIdx = dest;
    I_VSrc1Value = s1; I_VSrc2Value = s2; I_Imm = imm;
    tick();
    I_Valid = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (O_Valid !== 1'b1 && edges < 16) begin
      tick();
      edges++;
    end
  endtask

  task automatic drain;
    I_Ready = 1'b1;
    tick();
    I_Ready = 1'b0;
  endtask

  task automatic test_reset;
    I_RESET_N = 1'b0; I_Valid = 1'b0; I_OpSel = '0; I_DestRegIdx = '0;
    I_VSrc1Value = '0; I_VSrc2Value = '0; I_Imm = '0; I_Flush = 1'b0; I_Ready = 1'b0;
`ifdef VEXEC_LANE_MASK_EN
    I_LaneMask = 4'hF; I_VDestValue = '0;
`endif
    repeat (2) @(posedge I_CLOCK);
    #1;
    n_vec++; if (O_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", O_Valid); end
    n_vec++; if (O_Ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", O_Ready); end
    n_vec++; if (O_Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", O_Busy); end
    n_vec++; if (O_VALUOut !== 64'h0) begin n_err++; $display("FAIL reset_out got %h want 0", O_VALUOut); end
    n_vec++; if (O_DestRegIdx !== 4'h0) begin n_err++; $display("FAIL reset_dest got %h want 0", O_DestRegIdx); end
    n_vec++; if (O_IllegalOp !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %0b want 0", O_IllegalOp); end
    n_vec++; if (O_DbgState !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", O_DbgState); end
    @(posedge I_CLOCK);
    I_RESET_N = 1'b1;
    @(posedge I_CLOCK);
  endtask

  task automatic test_vadd;
    int e;
    start_op(3'd0, 4'd5, 64'h0001_FFFF_0003_7FFF, 64'h0001_0001_0004_0001, 16'h0);
    n_vec++; if (O_Busy !== 1'b1 || O_Valid !== 1'b0 || O_Ready !== 1'b0) begin
      n_err++; $display("FAIL vadd_accept busy=%0b valid=%0b ready=%0b want 1 0 0", O_Busy, O_Valid, O_Ready); end
    wait_done(e);
    n_vec++; if (e != 4) begin n_err++; $display("FAIL vadd_latency got %0d want 4", e); end
    n_vec++; if (O_VALUOut !== 64'h0002_0000_0007_8000) begin
      n_err++; $display("FAIL vadd_out got %h want 0002000000078000", O_VALUOut); end
    n_vec++; if (O_DestRegIdx !== 4'd5) begin n_err++; $display("FAIL vadd_dest got %0d want 5", O_DestRegIdx); end
    n_vec++; if (O_IllegalOp !== 1'b0) begin n_err++; $display("FAIL vadd_illegal got %0b want 0", O_IllegalOp); end
    drain();
    n_vec++; if (O_Valid !== 1'b0 || O_Ready !== 1'b1) begin
      n_err++; $display("FAIL vadd_drain valid=%0b ready=%0b want 0 1", O_Valid, O_Ready); end
  endtask

  task automatic test_vandi;
    int e;
    start_op(3'd3, 4'd1, 64'h1234_FFFF_0F0F_00FF, {$urandom, $urandom}, 16'h00F0);
    wait_done(e);
    n_vec++; if (e != 4) begin n_err++; $display("FAIL vandi_latency got %0d want 4", e); end
    n_vec++; if (O_VALUOut !== 64'h0030_00F0_0000_00F0) begin
      n_err++; $display("FAIL vandi_out got %h want 003000f0000000f0", O_VALUOut); end
    n_vec++; if (O_IllegalOp !== 1'b0) begin n_err++; $display("FAIL vandi_illegal got %0b want 0", O_IllegalOp); end
    drain();
  endtask

  task automatic test_backpressure;
    int e;
    start_op(3'd4, 4'd9, {$urandom, $urandom}, 64'hDEAD_BEEF_0123_4567, 16'h1111);
    wait_done(e);
    n_vec++; if (O_VALUOut !== 64'hDEAD_BEEF_0123_4567) begin
      n_err++; $display("FAIL vmov_out got %h want deadbeef01234567", O_VALUOut); end
    I_Valid = 1'b1; I_OpSel = 3'd0; I_DestRegIdx = 4'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (O_Valid !== 1'b1 || O_Ready !== 1'b0 || O_VALUOut !== 64'hDEAD_BEEF_0123_4567 || O_DestRegIdx !== 4'd9) begin
        n_err++; $display("FAIL bp_hold cyc=%0d valid=%0b ready=%0b out=%h dest=%0d want 1 0 deadbeef01234567 9",
                          c, O_Valid, O_Ready, O_VALUOut, O_DestRegIdx);
      end
    end
    I_Valid = 1'b0;
    drain();
    n_vec++; if (O_Ready !== 1'b1 || O_Valid !== 1'b0 || O_Busy !== 1'b0 || O_DestRegIdx !== 4'd9) begin
      n_err++; $display("FAIL bp_release ready=%0b valid=%0b busy=%0b dest=%0d want 1 0 0 9",
                        O_Ready, O_Valid, O_Busy, O_DestRegIdx); end
  endtask

  task automatic test_flush;
    logic seen_valid;
    start_op(3'd0, 4'd7, 64'h0001_FFFF_0003_7FFF, 64'h0001_0001_0004_0001, 16'h0);
    tick();
    I_Flush = 1'b1;
    tick();
    I_Flush = 1'b0;
    n_vec++; if (O_Ready !== 1'b1 || O_Valid !== 1'b0 || O_Busy !== 1'b0 || O_VALUOut !== 64'h0) begin
      n_err++; $display("FAIL flush_run ready=%0b valid=%0b busy=%0b out=%h want 1 0 0 0",
                        O_Ready, O_Valid, O_Busy, O_VALUOut); end
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (O_Valid !== 1'b0) seen_valid = 1'b1;
    end
    n_vec++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_valid got %0b want 0", seen_valid); end
    I_Valid = 1'b1; I_Flush = 1'b1;
    tick();
    I_Valid = 1'b0; I_Flush = 1'b0;
    n_vec++; if (O_Busy !== 1'b0 || O_Ready !== 1'b1) begin
      n_err++; $display("FAIL flush_idle busy=%0b ready=%0b want 0 1", O_Busy, O_Ready); end
  endtask

  task automatic test_reset_mid;
    int e;
    start_op(3'd0, 4'd4, 64'h0001_FFFF_0003_7FFF, 64'h0001_0001_0004_0001, 16'h0);
    tick();
    tick();
    n_vec++; if (O_VALUOut !== 64'h0000_0000_0007_8000) begin
      n_err++; $display("FAIL partial_out got %h want 0000000000078000", O_VALUOut); end
    I_RESET_N = 1'b0;
    #1;
    n_vec++; if (O_Valid !== 1'b0 || O_Busy !== 1'b0 || O_Ready !== 1'b1 || O_VALUOut !== 64'h0) begin
      n_err++; $display("FAIL reset_mid valid=%0b busy=%0b ready=%0b out=%h want 0 0 1 0",
                        O_Valid, O_Busy, O_Ready, O_VALUOut); end
    @(posedge I_CLOCK);
    I_RESET_N = 1'b1;
    @(posedge I_CLOCK);
    start_op(3'd5, 4'd2, {$urandom, $urandom}, {$urandom, $urandom}, 16'h00AB);
    wait_done(e);
    n_vec++; if (e != 4) begin n_err++; $display("FAIL vmovi_latency got %0d want 4", e); end
    n_vec++; if (O_VALUOut !== 64'h00AB_00AB_00AB_00AB || O_DestRegIdx !== 4'd2) begin
      n_err++; $display("FAIL vmovi_out got %h dest=%0d want 00ab00ab00ab00ab 2", O_VALUOut, O_DestRegIdx); end
    drain();
  endtask

  task automatic test_illegal;
    int e;
    start_op(3'd7, 4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
    wait_done(e);
    n_vec++; if (e != 4) begin n_err++; $display("FAIL illegal_latency got %0d want 4", e); end
    n_vec++; if (O_VALUOut !== 64'h0 || O_IllegalOp !== 1'b1) begin
      n_err++; $display("FAIL illegal_out got %h ill=%0b want 0 1", O_VALUOut, O_IllegalOp); end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [6:0] busy_seq;
    logic [6:0] valid_seq;
    I_Valid = 1'b1; I_Ready = 1'b1; I_OpSel = 3'd1; I_DestRegIdx = 4'd8;
    I_VSrc1Value = 64'h0000_0001_0002_FFFF; I_VSrc2Value = '0; I_Imm = 16'h0001;
    for (int c = 0; c < 7; c++) begin
      tick();
      busy_seq[c]  = O_Busy;
      valid_seq[c] = O_Valid;
      if (c == 4) begin
        n_vec++; if (O_VALUOut !== 64'h0001_0002_0003_0000) begin
          n_err++; $display("FAIL vaddi_out got %h want 0001000200030000", O_VALUOut); end
      end
    end
    I_Valid = 1'b0;
    n_vec++; if (busy_seq !== 7'b101_1111) begin
      n_err++; $display("FAIL b2b_busy got %b want 1011111", busy_seq); end
    n_vec++; if (valid_seq !== 7'b001_0000) begin
      n_err++; $display("FAIL b2b_valid got %b want 0010000", valid_seq); end
    repeat (6) tick();
    I_Ready = 1'b0;
    n_vec++; if (O_Ready !== 1'b1) begin n_err++; $display("FAIL b2b_final_ready got %0b want 1", O_Ready); end
  endtask

  initial begin
    test_reset();
    test_vadd();
    test_vandi();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
